// File: rtl/window_pkg.sv
// Shared types and defaults for the window finder: FSM state encoding,
// default probe width and default settle time.
package window_pkg;

   localparam int WF_WIDTH_DEF  = 4;
   localparam int WF_SETTLE_DEF = 1;
   localparam int WF_CNT_W      = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } wf_state_e;

endpackage

// File: rtl/window_settle_counter.sv
// Settle timer: cleared by load_i, advances while count_i is high and
// raises tc_o once SETTLE cycles have been spent since the load.
module window_settle_counter
   import window_pkg::*;
#(
   parameter int SETTLE = WF_SETTLE_DEF
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic load_i,
   input  logic count_i,
   output logic tc_o
);

   localparam logic [WF_CNT_W-1:0] TC_VAL = WF_CNT_W'(SETTLE - 1);

   logic [WF_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = '0;
      end else if (count_i && !tc_o) begin
         cnt_d = cnt_q + WF_CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/window_finder.sv
// Sweeps Value from 0 to all-ones against an external window comparator and
// records the lowest/highest in-window probe. Optional flag consistency
// checking is compiled in with WINDOW_FINDER_CHECK_EN.
module window_finder
   import window_pkg::*;
#(
   parameter int WIDTH  = WF_WIDTH_DEF,
   parameter int SETTLE = WF_SETTLE_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             too_high_i,
   input  logic             ok_i,
   input  logic             too_low_i,
   output logic [WIDTH-1:0] value_o,
   output logic [WIDTH-1:0] found_bottom_o,
   output logic [WIDTH-1:0] found_top_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             valid_o,
   output logic             error_o,
   output logic [1:0]       state_o
);

   localparam logic [1:0] S_IDLE   = ST_IDLE;
   localparam logic [1:0] S_SETTLE = ST_SETTLE;
   localparam logic [1:0] S_SAMPLE = ST_SAMPLE;
   localparam logic [1:0] S_DONE   = ST_DONE;

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic [WIDTH-1:0] fb_q, fb_d;
   logic [WIDTH-1:0] ft_q, ft_d;
   logic             valid_q, valid_d;
   logic             seen_ok_q, seen_ok_d;
   logic             cnt_load, cnt_en, cnt_tc;
   logic             accept_start;

   assign accept_start = (state_q == S_IDLE) && start_i;

   window_settle_counter #(
      .SETTLE (SETTLE)
   ) u_settle (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .load_i  (cnt_load),
      .count_i (cnt_en),
      .tc_o    (cnt_tc)
   );

   always_comb begin
      state_d   = state_q;
      value_d   = value_q;
      fb_d      = fb_q;
      ft_d      = ft_q;
      valid_d   = valid_q;
      seen_ok_d = seen_ok_q;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               value_d   = '0;
               fb_d      = '0;
               ft_d      = '0;
               valid_d   = 1'b0;
               seen_ok_d = 1'b0;
               cnt_load  = 1'b1;
               state_d   = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (cnt_tc) begin
               state_d = S_SAMPLE;
            end else begin
               cnt_en = 1'b1;
            end
         end
         S_SAMPLE: begin
            if (ok_i) begin
               if (!seen_ok_q) begin
                  fb_d      = value_q;
                  seen_ok_d = 1'b1;
               end
               ft_d = value_q;
            end
            // The sweep stops at all-ones rather than wrapping back to zero.
            if (value_q != {WIDTH{1'b1}}) begin
               value_d  = value_q + WIDTH'(1);
               cnt_load = 1'b1;
               state_d  = S_SETTLE;
            end else begin
               valid_d = seen_ok_d;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= S_IDLE;
         value_q   <= '0;
         fb_q      <= '0;
         ft_q      <= '0;
         valid_q   <= 1'b0;
         seen_ok_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         value_q   <= value_d;
         fb_q      <= fb_d;
         ft_q      <= ft_d;
         valid_q   <= valid_d;
         seen_ok_q <= seen_ok_d;
      end
   end

`ifdef WINDOW_FINDER_CHECK_EN
   logic       error_q, error_d;
   logic       seen_hi_q, seen_hi_d;
   logic [2:0] flags;
   logic       order_bad;

   assign flags     = {too_high_i, ok_i, too_low_i};
   // Flags must walk low -> ok -> high as Value rises; any step back is an error.
   assign order_bad = (too_low_i && (seen_ok_q || seen_hi_q)) || (ok_i && seen_hi_q);

   always_comb begin
      error_d   = error_q;
      seen_hi_d = seen_hi_q;
      if (accept_start) begin
         error_d   = 1'b0;
         seen_hi_d = 1'b0;
      end else if (state_q == S_SAMPLE) begin
         if (!$onehot(flags) || order_bad) begin
            error_d = 1'b1;
         end
         if (too_high_i) begin
            seen_hi_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         error_q   <= 1'b0;
         seen_hi_q <= 1'b0;
      end else begin
         error_q   <= error_d;
         seen_hi_q <= seen_hi_d;
      end
   end

   assign error_o = error_q;
`else
   logic unused_flags;
   assign unused_flags = ^{too_high_i, too_low_i, accept_start};
   assign error_o      = 1'b0;
`endif

   assign value_o        = value_q;
   assign found_bottom_o = fb_q;
   assign found_top_o    = ft_q;
   assign busy_o         = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
   assign done_o         = (state_q == S_DONE);
   assign valid_o        = valid_q;
   assign state_o        = state_q;

endmodule

// File: tb/tb_window_finder.sv
// Bench for window_finder: two instances (SETTLE=1 and SETTLE=3) sweep against
// a behavioural window comparator; expected limits are queued at Start.
module tb_window_finder;
   import window_pkg::*;

   localparam int W        = 4;
   localparam int EXP_LAT1 = (1 << W) * 2;
   localparam int EXP_LAT3 = (1 << W) * 4;
   localparam int NVEC     = 7;
`ifdef WINDOW_FINDER_CHECK_EN
   localparam bit CHECK_EN = 1'b1;
`else
   localparam bit CHECK_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         start;
   logic [W-1:0] top_lim, bot_lim;
   logic         force_bad;

   logic         hi1, ok1, lo1, busy1, done1, valid1, err1;
   logic [W-1:0] value1, fb1, ft1;
   logic [1:0]   st1;
   logic         hi3, ok3, lo3, busy3, done3, valid3, err3;
   logic [W-1:0] value3, fb3, ft3;
   logic [1:0]   st3;

   // Comparator: above top is high, otherwise inside if at/above bottom, else low.
   function automatic logic [2:0] cmp(input logic [W-1:0] v, input logic [W-1:0] t,
                                      input logic [W-1:0] b, input logic f);
      logic h, o, l;
      h = (v > t);
      o = !h && (v >= b);
      l = !h && !o;
      if (f && v == W'(6)) begin
         h = 1'b1;
         o = 1'b1;
         l = 1'b0;
      end
      return {h, o, l};
   endfunction

   always_comb {hi1, ok1, lo1} = cmp(value1, top_lim, bot_lim, force_bad);
   always_comb {hi3, ok3, lo3} = cmp(value3, top_lim, bot_lim, force_bad);

   window_finder #(.WIDTH(W), .SETTLE(1)) dut (
      .clk_i (clk), .rst_i (rst), .start_i (start),
      .too_high_i (hi1), .ok_i (ok1), .too_low_i (lo1),
      .value_o (value1), .found_bottom_o (fb1), .found_top_o (ft1),
      .busy_o (busy1), .done_o (done1), .valid_o (valid1), .error_o (err1),
      .state_o (st1)
   );

   window_finder #(.WIDTH(W), .SETTLE(3)) dut3 (
      .clk_i (clk), .rst_i (rst), .start_i (start),
      .too_high_i (hi3), .ok_i (ok3), .too_low_i (lo3),
      .value_o (value3), .found_bottom_o (fb3), .found_top_o (ft3),
      .busy_o (busy3), .done_o (done3), .valid_o (valid3), .error_o (err3),
      .state_o (st3)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [2*W+1:0] exp1_q[$];
   logic [2*W+1:0] exp3_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic compare_exp(input string tag, input logic [2*W+1:0] e,
                              input logic [W-1:0] fb, input logic [W-1:0] ft,
                              input logic valid, input logic err);
      check({tag, "_err"},    32'(err),   32'(e[2*W+1]));
      check({tag, "_valid"},  32'(valid), 32'(e[2*W]));
      check({tag, "_bottom"}, 32'(fb),    32'(e[2*W-1:W]));
      check({tag, "_top"},    32'(ft),    32'(e[W-1:0]));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_value1"}, 32'(value1), 0);
      check({tag, "_fb1"},    32'(fb1),    0);
      check({tag, "_ft1"},    32'(ft1),    0);
      check({tag, "_ctl1"},   32'({busy1, done1, valid1, err1, st1}), 0);
      check({tag, "_value3"}, 32'(value3), 0);
      check({tag, "_fb3"},    32'(fb3),    0);
      check({tag, "_ft3"},    32'(ft3),    0);
      check({tag, "_ctl3"},   32'({busy3, done3, valid3, err3, st3}), 0);
   endtask

   // ---------------- driver ----------------
   task automatic run_sweep(input string tag, input logic [2*W+1:0] e,
                            input int restart_at, input int reset_at);
      int lat1, lat3, nd1, nd3;
      logic [2*W+1:0] last1, last3;
      lat1 = -1; lat3 = -1; nd1 = 0; nd3 = 0;
      last1 = e; last3 = e;
      @(negedge clk);
      start = 1'b1;
      exp1_q.push_back(e);
      exp3_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      for (int cyc = 1; cyc <= 80; cyc++) begin
         @(negedge clk);
         if (done1) begin
            nd1++;
            lat1 = cyc;
            if (exp1_q.size() == 0) check({tag, "_unexpected_done1"}, 1, 0);
            else begin
               last1 = exp1_q.pop_front();
               compare_exp({tag, "_s1"}, last1, fb1, ft1, valid1, err1);
            end
         end
         if (done3) begin
            nd3++;
            lat3 = cyc;
            if (exp3_q.size() == 0) check({tag, "_unexpected_done3"}, 1, 0);
            else begin
               last3 = exp3_q.pop_front();
               compare_exp({tag, "_s3"}, last3, fb3, ft3, valid3, err3);
            end
         end
         if (cyc == 5) check({tag, "_busy_mid"}, 32'({busy1, busy3}), 32'b11);
         if (reset_at > 0 && cyc == reset_at + 1) begin
            check_zero({tag, "_after_reset"});
            rst = 1'b0;
         end
         start = (cyc == restart_at);
         if (reset_at > 0 && cyc == reset_at) begin
            rst = 1'b1;
            exp1_q.delete();
            exp3_q.delete();
         end
      end
      start = 1'b0;
      if (reset_at == 0) begin
         check({tag, "_ndone1"}, 32'(nd1), 1);
         check({tag, "_ndone3"}, 32'(nd3), 1);
         check({tag, "_latency1"}, 32'(lat1), EXP_LAT1);
         check({tag, "_latency3"}, 32'(lat3), EXP_LAT3);
         check({tag, "_value_end"}, 32'({value1, value3}), 32'({W'(15), W'(15)}));
         compare_exp({tag, "_hold1"}, last1, fb1, ft1, valid1, err1);
         compare_exp({tag, "_hold3"}, last3, fb3, ft3, valid3, err3);
      end else begin
         check({tag, "_ndone_after_reset"}, 32'(nd1 + nd3), 0);
         check({tag, "_found_after_reset"}, 32'({fb1, ft1, fb3, ft3}), 0);
      end
      check({tag, "_idle_busy"}, 32'({busy1, busy3}), 0);
   endtask

   // Reference: lowest and highest in-window values over the full sweep.
   function automatic logic [2*W+1:0] model(input logic [W-1:0] t, input logic [W-1:0] b,
                                            input logic f);
      logic [W-1:0] lo, hi;
      logic seen;
      lo = '0; hi = '0; seen = 1'b0;
      for (int v = 0; v < (1 << W); v++) begin
         if (v >= int'(b) && v <= int'(t)) begin
            if (!seen) lo = W'(v);
            hi = W'(v);
            seen = 1'b1;
         end
      end
      return {f & CHECK_EN, seen, lo, hi};
   endfunction

   typedef struct {
      logic [W-1:0] top;
      logic [W-1:0] bot;
      logic         fbad;
      logic [W-1:0] exp_bot;
      logic [W-1:0] exp_top;
      logic         exp_valid;
      logic         exp_err;
   } vec_t;

   vec_t vecs[NVEC];

   initial begin
      vecs[0] = '{top: 4'd11, bot: 4'd4, fbad: 1'b0, exp_bot: 4'd4, exp_top: 4'd11, exp_valid: 1'b1, exp_err: 1'b0};
      vecs[1] = '{top: 4'd15, bot: 4'd0, fbad: 1'b0, exp_bot: 4'd0, exp_top: 4'd15, exp_valid: 1'b1, exp_err: 1'b0};
      vecs[2] = '{top: 4'd3,  bot: 4'd9, fbad: 1'b0, exp_bot: 4'd0, exp_top: 4'd0,  exp_valid: 1'b0, exp_err: 1'b0};
      vecs[3] = '{top: 4'd11, bot: 4'd4, fbad: 1'b1, exp_bot: 4'd4, exp_top: 4'd11, exp_valid: 1'b1, exp_err: CHECK_EN};
      for (int i = 4; i < NVEC; i++) begin
         logic [2*W+1:0] m;
         vecs[i].top  = W'($urandom_range(0, 15));
         vecs[i].bot  = W'($urandom_range(0, 15));
         vecs[i].fbad = 1'b0;
         m = model(vecs[i].top, vecs[i].bot, 1'b0);
         vecs[i].exp_err   = m[2*W+1];
         vecs[i].exp_valid = m[2*W];
         vecs[i].exp_bot   = m[2*W-1:W];
         vecs[i].exp_top   = m[W-1:0];
      end

      rst = 1'b1; start = 1'b0; force_bad = 1'b0; top_lim = '0; bot_lim = '0;
      repeat (3) @(negedge clk);
      check_zero("reset_state");
      rst = 1'b0;

      for (int i = 0; i < NVEC; i++) begin
         top_lim   = vecs[i].top;
         bot_lim   = vecs[i].bot;
         force_bad = vecs[i].fbad;
         run_sweep($sformatf("vec%0d", i),
                   {vecs[i].exp_err, vecs[i].exp_valid, vecs[i].exp_bot, vecs[i].exp_top}, 0, 0);
      end

      // Start re-pulsed mid-sweep must not restart or add a second Done.
      top_lim = 4'd11; bot_lim = 4'd4; force_bad = 1'b0;
      run_sweep("restart_ignored", {1'b0, 1'b1, 4'd4, 4'd11}, 10, 0);

      // Reset mid-sweep clears everything and suppresses Done.
      run_sweep("mid_reset", {1'b0, 1'b1, 4'd4, 4'd11}, 0, 20);

      // Error from the forced case is gone after a fresh sweep.
      check("err_cleared", 32'({err1, err3}), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got %0d expected %0d", 1, 0);
      $fatal(1, "simulation time limit reached");
   end

endmodule

// File: doc/window_finder.md
WINDOW_FINDER -- requirements
Module: window_finder

Interface
REQ-001 Parameter WIDTH, default 4, bit width of Value and of the found limits.
REQ-002 Parameter SETTLE, default 1, range 1..15, clock cycles Value is held before the comparator flags are sampled.
REQ-003 Clock  input  1  sole clock, all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Start  input  1  request one sweep; honoured only in IDLE.
REQ-006 Too_High  input  1  comparator flag: Value above window.
REQ-007 OK  input  1  comparator flag: Value inside window, limits inclusive.
REQ-008 Too_Low  input  1  comparator flag: Value below window.
REQ-009 Value  output  WIDTH  probe value driven to the external window comparator.
REQ-010 Found_Bottom  output  WIDTH  lowest Value sampled with OK=1.
REQ-011 Found_Top  output  WIDTH  highest Value sampled with OK=1.
REQ-012 Busy  output  1  high in SETTLE and SAMPLE states.
REQ-013 Done  output  1  one-cycle pulse when a sweep completes.
REQ-014 Valid  output  1  at least one OK sample in the last completed sweep.
REQ-015 Error  output  1  sticky flag-consistency error (see Configuration).

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE, DONE.
REQ-017 IDLE with Start=1: Value<=0, Found_Bottom/Found_Top/Valid/Error/seen-flags cleared, settle counter<=0, next state SETTLE.
REQ-018 SETTLE: hold Value for SETTLE cycles, then go to SAMPLE.
REQ-019 SAMPLE, OK=1 and no OK yet seen: Found_Bottom<=Value, Found_Top<=Value, set seen_ok.
REQ-020 SAMPLE, OK=1 and seen_ok already set: Found_Top<=Value; Found_Bottom unchanged.
REQ-021 SAMPLE, Value below all-ones: Value<=Value+1, next state SETTLE.
REQ-022 SAMPLE, Value equal to all-ones: Value holds (no wrap), next state DONE.
REQ-023 DONE: Done=1 for exactly one cycle, Valid=seen_ok, next state IDLE.
REQ-024 Each probe value SHALL occupy SETTLE+1 cycles.
REQ-025 With Start sampled at edge k, Done SHALL be high in the cycle after edge k+2^WIDTH*(SETTLE+1); with defaults that is 33 cycles after Start.
REQ-026 Start in SETTLE, SAMPLE or DONE SHALL be ignored, with no effect on the sweep.
REQ-027 No OK sampled: Valid=0, Found_Bottom=Found_Top=0.
REQ-028 Found_Bottom, Found_Top, Valid and Error SHALL hold after DONE until the next accepted Start or Reset.

Reset
REQ-029 Reset=1 at a clock edge SHALL force IDLE; Value, Found_Bottom, Found_Top, Busy, Done, Valid, Error SHALL all be 0 in the following cycle, including mid-sweep.
REQ-030 Reset SHALL take priority over Start.

Configuration
REQ-031 With macro WINDOW_FINDER_CHECK_EN defined, SAMPLE SHALL set Error if the three flags are not one-hot.
REQ-032 With WINDOW_FINDER_CHECK_EN defined, SAMPLE SHALL also set Error on an order violation: Too_Low after OK or Too_High was seen, or OK after Too_High was seen.
REQ-033 With WINDOW_FINDER_CHECK_EN defined, Error SHALL be sticky until the next accepted Start; the sweep still completes normally.
REQ-034 Without WINDOW_FINDER_CHECK_EN, Error SHALL be constant 0 and no checking logic synthesised.

Structure
REQ-035 Package window_pkg SHALL hold the FSM state enum, the default WIDTH and the default SETTLE.
REQ-036 The settle counter SHALL be a sub-module window_settle_counter (load, count, terminal-count output); all other logic stays in window_finder.

Verification (bench instantiates the existing window comparator, Value fed back from window_finder)
REQ-037 Top_Limit=11, Bottom_Limit=4, Start pulse -> Done 33 cycles later, Found_Bottom=4, Found_Top=11, Valid=1, Error=0.
REQ-038 Top_Limit=15, Bottom_Limit=0 -> Found_Bottom=0, Found_Top=15, Valid=1; Value ends at 15 with no wrap.
REQ-039 Top_Limit=3, Bottom_Limit=9 (empty window) -> Valid=0, Found_Bottom=Found_Top=0, Done after 33 cycles.
REQ-040 Start re-pulsed at cycle 10 of a sweep -> ignored, single Done at cycle 33; Reset at cycle 20 -> all outputs 0 next cycle, no Done.
REQ-041 WINDOW_FINDER_CHECK_EN defined, flags forced OK=1 and Too_High=1 at Value=6 -> Error=1, held through DONE, cleared by next Start; without the macro -> Error stays 0.
REQ-042 SETTLE=3 with limits 11/4 -> Done 65 cycles after Start, same Found values as REQ-037.
